pa_dtu_cdc_hs_arb: RTL and testbench
====================================

# pa_dtu_cdc_hs_arb

Single-clock four-phase handshake controller and round-robin arbiter that shares one level-based CDC channel among several debug-trigger-unit requesters. It captures a granted requester's payload, holds it stable while driving a request level toward the remote domain, synchronizes the returning acknowledge through a 3-flop level synchronizer, and reports completion to the owner. It sits in the DTU on the local-clock side of every cross-domain debug message path.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (legal 2..8)
- DATA_W, 32, payload width
- TIMEOUT_CYC, 1023, ack-wait limit in clk cycles (used only with PA_DTU_CDC_TIMEOUT_EN; legal 1..65535)

Ports:
- clk  input  1  local clock
- rst_b  input  1  reset rst_b, asynchronous, active-low; clock clk
- req_vld  input  NUM_REQ  per-requester transfer request; held until req_gnt
- req_data  input  NUM_REQ*DATA_W  payloads, requester i at bits [i*DATA_W +: DATA_W]
- req_gnt  output  NUM_REQ  one-hot, one-cycle accept pulse
- req_done  output  NUM_REQ  one-hot, one-cycle completion pulse
- req_err  output  NUM_REQ  one-hot, one-cycle timeout pulse (tied 0 without macro)
- cdc_req  output  1  registered request level to remote domain
- cdc_data  output  DATA_W  registered payload, stable whenever cdc_req=1
- cdc_ack  input  1  asynchronous acknowledge level from remote domain
- busy  output  1  high in any state other than IDLE

## Operation
- Internal ack_sync = cdc_ack through three reset-to-0 flops; only ack_sync is used.
- States: IDLE, REQ_HI, REQ_LO.
- IDLE: if any req_vld and ack_sync=0, pick winner i by round robin starting at ptr; req_gnt[i]=1 combinationally this cycle; at the edge: cdc_data<=req_data[i], cdc_req<=1, owner<=i, ptr<=(i+1) mod NUM_REQ, state<=REQ_HI. With ack_sync=1 in IDLE (stale ack) no grant.
- REQ_HI: wait ack_sync=1; at that edge cdc_req<=0, state<=REQ_LO.
- REQ_LO: wait ack_sync=0; that cycle req_done[owner]=1 (combinational); at the edge state<=IDLE.
- Round robin: priority order ptr, ptr+1, ... wrapping at NUM_REQ; ptr updates only on grant.
- cdc_data changes only on a grant edge; never while cdc_req=1 or REQ_LO.
- req_vld deassert before grant: requester simply not considered; no error.

## Timing
- Reset values: cdc_req=0, cdc_data=0, busy=0, req_gnt/req_done/req_err=0, ptr=0, owner=0, sync flops=0, state IDLE.
- Grant cycle G: req_gnt pulse; cdc_req=1 from G+1.
- cdc_ack rising sampled at edge E: ack_sync=1 after edge E+2; cdc_req falls at edge E+3.
- cdc_ack falling sampled at edge F: req_done pulse in cycle after edge F+2; IDLE after F+3.
- Back-to-back: next grant may occur in the first IDLE cycle (cycle after req_done).
- Ack that never toggles: controller waits forever (without macro).
- Reset asserted mid-transfer: cdc_req drops asynchronously; no done/err pulse; remote side must tolerate abandoned handshake.

## Configuration
- PA_DTU_CDC_TIMEOUT_EN defined: 16-bit counter cleared on entry to REQ_HI, increments each REQ_HI cycle; when it reaches TIMEOUT_CYC with ack_sync still 0, req_err[owner] pulses that cycle, cdc_req<=0, state<=REQ_LO (normal ack-low wait, no req_done at exit). REQ_LO has no timeout. If ack_sync=1 in the same cycle as expiry, ack wins: no error.
- Not defined: no counter, req_err tied 0, REQ_HI waits indefinitely.

## Test plan
- Single requester: req_vld=4'b0010, data 0xDEADBEEF, remote ack echoes cdc_req after 2 cycles -> gnt[1] once, cdc_data=0xDEADBEEF while cdc_req=1, done[1] once, busy low after.
- All four requesting continuously, ptr=0 -> grant order 0,1,2,3,0; each grant's cdc_data matches its payload.
- Stale ack: cdc_ack=1 at reset release with req_vld=1 -> no grant until ack_sync=0, then grant.
- ack rise at edge E -> cdc_req falls exactly at E+3; ack fall at F -> done in cycle after F+2.
- Timeout (macro on, TIMEOUT_CYC=8), ack held 0 -> err[owner] at 8th REQ_HI cycle, cdc_req falls, no done, next grant proceeds.
- Reset asserted while in REQ_HI -> cdc_req, busy, all pulses 0 immediately; after release a fresh request completes normally with ptr=0.

Source files
------------

// File: rtl/pa_dtu_cdc_hs_arb.sv
// Round-robin arbiter plus four-phase request/ack controller sharing one level-based CDC channel.
// Optional ack-wait timeout is compiled in with PA_DTU_CDC_TIMEOUT_EN.
module pa_dtu_cdc_hs_arb #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic [NUM_REQ-1:0]          req_vld,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_gnt,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [NUM_REQ-1:0]          req_err,
    output logic                        cdc_req,
    output logic [DATA_W-1:0]           cdc_data,
    input  logic                        cdc_ack,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_HI = 2'd1,
        ST_REQ_LO = 2'd2
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_chk
        $error("pa_dtu_cdc_hs_arb: illegal parameter value");
    end

    state_t               state_q, state_d;
    logic [2:0]           sync_q;
    logic                 ack_sync;
    logic                 cdc_req_q, cdc_req_d;
    logic [DATA_W-1:0]    cdc_data_q, cdc_data_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W:0]       cand;
    logic                 grant_en;
    logic                 done_en;
    logic [DATA_W-1:0]    req_data_arr [NUM_REQ];

`ifdef PA_DTU_CDC_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]          to_cnt_q, to_cnt_d;
    logic                 to_flag_q, to_flag_d;
    logic                 err_en;
`endif

    // Only the third synchronizer stage is ever observed by the FSM.
    assign ack_sync = sync_q[2];

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        assign req_gnt[gi]      = grant_en && (win_idx == PTR_W'(gi));
        assign req_done[gi]     = done_en && (owner_q == PTR_W'(gi));
`ifdef PA_DTU_CDC_TIMEOUT_EN
        assign req_err[gi]      = err_en && (owner_q == PTR_W'(gi));
`else
        assign req_err[gi]      = 1'b0;
`endif
    end

    // Scan from the far end toward ptr so the last hit is the highest-priority requester.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (req_vld[cand[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cdc_req_d  = cdc_req_q;
        cdc_data_d = cdc_data_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_en   = 1'b0;
        done_en    = 1'b0;
`ifdef PA_DTU_CDC_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        to_flag_d  = to_flag_q;
        err_en     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld && !ack_sync) begin
                    grant_en   = 1'b1;
                    cdc_data_d = req_data_arr[win_idx];
                    cdc_req_d  = 1'b1;
                    owner_d    = win_idx;
                    ptr_d      = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                    state_d    = ST_REQ_HI;
`ifdef PA_DTU_CDC_TIMEOUT_EN
                    to_cnt_d   = '0;
                    to_flag_d  = 1'b0;
`endif
                end
            end
            ST_REQ_HI: begin
                if (ack_sync) begin
                    cdc_req_d = 1'b0;
                    state_d   = ST_REQ_LO;
                end
`ifdef PA_DTU_CDC_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    // Abandon the wait; REQ_LO still waits for a clean low ack before reuse.
                    err_en    = 1'b1;
                    cdc_req_d = 1'b0;
                    to_flag_d = 1'b1;
                    state_d   = ST_REQ_LO;
                end
                else begin
                    to_cnt_d  = to_cnt_q + 16'd1;
                end
`endif
            end
            ST_REQ_LO: begin
                if (!ack_sync) begin
`ifdef PA_DTU_CDC_TIMEOUT_EN
                    done_en = !to_flag_q;
`else
                    done_en = 1'b1;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            sync_q     <= '0;
            cdc_req_q  <= 1'b0;
            cdc_data_q <= '0;
            ptr_q      <= '0;
            owner_q    <= '0;
`ifdef PA_DTU_CDC_TIMEOUT_EN
            to_cnt_q   <= '0;
            to_flag_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[1:0], cdc_ack};
            cdc_req_q  <= cdc_req_d;
            cdc_data_q <= cdc_data_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
`ifdef PA_DTU_CDC_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            to_flag_q  <= to_flag_d;
`endif
        end
    end

    assign cdc_req  = cdc_req_q;
    assign cdc_data = cdc_data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pa_dtu_cdc_hs_arb.sv
// Directed self-checking bench for pa_dtu_cdc_hs_arb (4 requesters, 32-bit payload, TIMEOUT_CYC=8).
// The timeout scenario runs only when PA_DTU_CDC_TIMEOUT_EN is defined.
module tb_pa_dtu_cdc_hs_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                       clk = 1'b0;
    logic                       rst_b;
    logic [NUM_REQ-1:0]         req_vld;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_gnt;
    logic [NUM_REQ-1:0]         req_done;
    logic [NUM_REQ-1:0]         req_err;
    logic                       cdc_req;
    logic [DATA_W-1:0]          cdc_data;
    logic                       cdc_ack;
    logic                       busy;

    logic        ack_man;
    logic        echo_en;
    logic        cont_en;
    logic [1:0]  echo_pipe;
    logic [NUM_REQ-1:0] gnt_seen;
    int          gnt_cnt [NUM_REQ];
    int          done_cnt [NUM_REQ];
    int          err_cnt [NUM_REQ];
    int          gnt_q [$];
    logic [31:0] data_q [$];
    logic        prev_req;
    logic [31:0] prev_data;
    int          n_chk;
    int          n_fail;

    pa_dtu_cdc_hs_arb #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .req_vld (req_vld),
        .req_data(req_data),
        .req_gnt (req_gnt),
        .req_done(req_done),
        .req_err (req_err),
        .cdc_req (cdc_req),
        .cdc_data(cdc_data),
        .cdc_ack (cdc_ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Remote side: either a manual level or cdc_req echoed two cycles late.
    assign cdc_ack = echo_en ? echo_pipe[1] : ack_man;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester/remote environment: drops a requester's valid the cycle after its grant.
    always @(negedge clk) begin
        echo_pipe = {echo_pipe[0], cdc_req};
        if (!cont_en) req_vld = req_vld & ~gnt_seen;
        gnt_seen = '0;
    end

    // Monitor samples just before each rising edge.
    always @(negedge clk) begin
        #4;
        if (!rst_b) begin
            prev_req = 1'b0;
        end else begin
            if (req_gnt != '0) begin
                check_val("gnt_onehot", 64'($onehot(req_gnt)), 64'd1);
                gnt_seen = req_gnt;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_gnt[i]) begin
                        gnt_cnt[i]++;
                        gnt_q.push_back(i);
                        $display("grant    req=%0d data=0x%08h", i, req_data[i*DATA_W +: DATA_W]);
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_done[i]) begin
                    done_cnt[i]++;
                    $display("done     req=%0d", i);
                end
                if (req_err[i]) begin
                    err_cnt[i]++;
                    $display("timeout  req=%0d", i);
                end
            end
            if (cdc_req && prev_req) check_val("data_stable", cdc_data, prev_data);
            if (cdc_req && !prev_req) data_q.push_back(cdc_data);
            prev_req  = cdc_req;
            prev_data = cdc_data;
        end
    end

    task automatic wait_gnts(input int n, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (gnt_q.size() >= n) return;
            @(negedge clk);
        end
        check_val(tag, 64'(gnt_q.size()), 64'(n));
    endtask

    task automatic wait_done(input int idx, input int target, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (done_cnt[idx] >= target) return;
            @(negedge clk);
        end
        check_val(tag, 64'(done_cnt[idx]), 64'(target));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check_val(tag, 64'(busy), 64'd0);
    endtask

    int          exp_order [5] = '{0, 1, 2, 3, 0};
    logic [31:0] exp_pay   [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
    int          done2_before;

    initial begin
        n_chk = 0; n_fail = 0;
        rst_b = 1'b0; req_vld = '0; req_data = '0;
        ack_man = 1'b0; echo_en = 1'b0; cont_en = 1'b0;
        echo_pipe = '0; gnt_seen = '0; prev_req = 1'b0; prev_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_cdc_req", cdc_req, 0);
        check_val("rst_cdc_data", cdc_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_gnt", req_gnt, 0);
        check_val("rst_done", req_done, 0);
        check_val("rst_err", req_err, 0);
        @(negedge clk); #1;
        rst_b = 1'b1;

        // Single requester with echoing remote
        echo_en = 1'b1;
        req_data[1*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        req_vld = 4'b0010;
        wait_done(1, 1, "single_done_timeout");
        repeat (2) @(negedge clk);
        #1;
        check_val("single_gnt_cnt", gnt_cnt[1], 1);
        check_val("single_done_cnt", done_cnt[1], 1);
        check_val("single_other_gnt", gnt_cnt[0] + gnt_cnt[2] + gnt_cnt[3], 0);
        check_val("single_data", (data_q.size() > 0) ? data_q[0] : 32'h0, 32'hDEAD_BEEF);
        check_val("single_busy_after", busy, 0);
        data_q.delete(); gnt_q.delete();

        // Stale ack blocks grants, then exact grant/ack timing
        echo_en = 1'b0; ack_man = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        req_data[3*DATA_W +: DATA_W] = 32'h1234_5678;
        req_vld = 4'b1000;
        repeat (6) @(negedge clk);
        #1;
        check_val("stale_no_gnt", gnt_cnt[3], 0);
        check_val("stale_busy", busy, 0);
        ack_man = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("stale_gnt_f1", req_gnt, 4'b0000);
        @(posedge clk); #1;
        check_val("stale_gnt_f2", req_gnt, 4'b1000);
        @(posedge clk); #1;
        check_val("gnt_cdc_req", cdc_req, 1);
        check_val("gnt_cdc_data", cdc_data, 32'h1234_5678);
        check_val("gnt_busy", busy, 1);
        @(negedge clk); #1;
        ack_man = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("req_hold_e2", cdc_req, 1);
        @(posedge clk); #1;
        check_val("req_fall_e3", cdc_req, 0);
        @(negedge clk); #1;
        ack_man = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("done_f1", req_done, 4'b0000);
        @(posedge clk); #1;
        check_val("done_f2", req_done, 4'b1000);
        @(posedge clk); #1;
        check_val("idle_f3_busy", busy, 0);
        check_val("idle_f3_done", req_done, 4'b0000);

        // Four requesters continuously, ptr back at 0
        @(negedge clk); #1;
        gnt_q.delete(); data_q.delete();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = exp_pay[i];
        echo_en = 1'b1; cont_en = 1'b1; req_vld = 4'b1111;
        wait_gnts(5, "rr_gnt_timeout");
        #1;
        cont_en = 1'b0; req_vld = '0;
        wait_idle("rr_idle_timeout");
        check_val("rr_gnt_count", gnt_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < gnt_q.size()) check_val("rr_order", gnt_q[k], exp_order[k]);
            if (k < data_q.size()) check_val("rr_data", data_q[k], exp_pay[exp_order[k]]);
        end

        // Reset while in REQ_HI
        @(negedge clk); #1;
        echo_en = 1'b0; ack_man = 1'b0;
        gnt_q.delete();
        done2_before = done_cnt[2];
        req_data[2*DATA_W +: DATA_W] = 32'h0BAD_F00D;
        req_vld = 4'b0100;
        wait_gnts(1, "rst_mid_gnt_timeout");
        @(negedge clk); #1;
        check_val("rst_mid_req_before", cdc_req, 1);
        #2;
        rst_b = 1'b0;
        #1;
        check_val("rst_mid_cdc_req", cdc_req, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_pulses", {req_gnt, req_done, req_err}, 12'h000);
        @(negedge clk); #1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        gnt_q.delete(); data_q.delete();
        req_data[1*DATA_W +: DATA_W] = 32'h1111_2222;
        req_data[3*DATA_W +: DATA_W] = 32'h3333_4444;
        echo_en = 1'b1;
        req_vld = 4'b1010;
        wait_gnts(2, "post_rst_gnt_timeout");
        wait_idle("post_rst_idle_timeout");
        check_val("post_rst_first", (gnt_q.size() > 0) ? gnt_q[0] : -1, 1);
        check_val("post_rst_second", (gnt_q.size() > 1) ? gnt_q[1] : -1, 3);
        check_val("post_rst_data1", (data_q.size() > 0) ? data_q[0] : 32'h0, 32'h1111_2222);
        check_val("post_rst_no_done2", done_cnt[2], done2_before);

`ifdef PA_DTU_CDC_TIMEOUT_EN
        // Ack never arrives: err on the 8th REQ_HI cycle, no done, channel reusable
        @(negedge clk); #1;
        echo_en = 1'b0; ack_man = 1'b0;
        gnt_q.delete();
        req_data[0*DATA_W +: DATA_W] = 32'h5555_AAAA;
        req_vld = 4'b0001;
        for (int i = 0; i < 50 && !req_gnt[0]; i++) begin
            @(negedge clk); #4;
        end
        check_val("to_gnt_seen", req_gnt[0], 1);
        @(posedge clk); #1;
        repeat (6) @(posedge clk);
        #1;
        check_val("to_err_c7", req_err, 4'b0000);
        @(posedge clk); #1;
        check_val("to_err_c8", req_err, 4'b0001);
        @(posedge clk); #1;
        check_val("to_req_fall", cdc_req, 0);
        check_val("to_err_gone", req_err, 4'b0000);
        done2_before = done_cnt[0];
        wait_idle("to_idle_timeout");
        check_val("to_no_done", done_cnt[0], done2_before);
        check_val("to_err_cnt", err_cnt[0], 1);
        @(negedge clk); #1;
        echo_en = 1'b1;
        req_data[1*DATA_W +: DATA_W] = 32'h7777_8888;
        req_vld = 4'b0010;
        wait_done(1, done_cnt[1] + 1, "to_next_done_timeout");
        check_val("to_next_gnt", (gnt_q.size() > 1) ? gnt_q[1] : -1, 1);
`else
        check_val("no_err_pulses", err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3], 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
